scan_decoder: RTL and testbench
===============================

SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 3, select width; OUT_W = 2**SEL_W is derived and not overridable.
REQ-002 SHALL have parameter DIV_W, default 16, width of the scan period counter.
REQ-003 SHALL have parameter ACTIVE_LOW, default 0; when 1, O is inverted bitwise at the output register input.
REQ-004 SHALL use one clock and synchronous, active-high reset, as already decided.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 Enable  input  1  1 = decoder active; 0 = outputs inactive.
REQ-008 Mode  input  1  0 = DIRECT (decode S); 1 = SCAN (auto-stepping index).
REQ-009 S  input  SEL_W  select in DIRECT mode; start index for Load in SCAN mode.
REQ-010 Load  input  1  SCAN mode: one-cycle pulse that loads S into the index.
REQ-011 Div  input  DIV_W  SCAN step period, in cycles, minus one.
REQ-012 O  output  OUT_W  registered one-hot decode of Idx (polarity per ACTIVE_LOW).
REQ-013 Idx  output  SEL_W  registered current index.
REQ-014 Valid  output  1  registered; 1 when O carries an active decode.
REQ-015 Wrap  output  1  one-cycle pulse, set in the cycle after Idx steps from OUT_W-1 to 0 in SCAN.

Function
REQ-016 SHALL implement FSM states OFF, DIRECT, SCAN, selected each cycle by Enable and Mode.
REQ-017 State selection: Enable=0 -> OFF; Enable=1, Mode=0 -> DIRECT; Enable=1, Mode=1 -> SCAN.
REQ-018 OFF: O inactive (all 0, or all 1 if ACTIVE_LOW); Valid=0; Wrap=0; period counter cleared; Idx held.
REQ-019 DIRECT: Idx <= S and O <= one-hot(S) at the next edge, giving latency exactly 1 cycle; Valid=1; Wrap=0.
REQ-020 SCAN: the period counter counts 0..Div; on the cycle it equals Div, it clears and Idx increments modulo OUT_W.
REQ-021 Div=0 SHALL step Idx every cycle; Div=max SHALL step every 2**DIV_W cycles.
REQ-022 Wrap SHALL assert for exactly one cycle, coincident with O showing index 0 after a step from OUT_W-1.
REQ-023 Load in SCAN SHALL set Idx <= S and clear the counter; Load has priority over a simultaneous step, and no Wrap is produced.
REQ-024 Load outside SCAN SHALL be ignored.
REQ-025 Entering SCAN from any state SHALL start from the current Idx with the counter cleared.
REQ-026 Div changes SHALL take effect on the next counter compare; if counter > new Div, the step occurs when the counter wraps naturally at its all-ones value.
REQ-027 O SHALL always equal the decode of Idx when Valid=1; it SHALL never hold more than one active bit.

Reset
REQ-028 On rst, Idx=0, O inactive, Valid=0, Wrap=0, counter=0, and FSM=OFF, all on the same edge.
REQ-029 rst SHALL override Enable, Load and Mode, including a reset asserted mid-scan.
REQ-030 The first active output after reset release SHALL appear 1 cycle after Enable is sampled high.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (OFF, DIRECT, SCAN) and the mode encodings.
REQ-032 The combinational one-hot decode SHALL be a sub-module named onehot_dec, parameterised by SEL_W; it carries no state.

Verification
REQ-033 rst, then Enable=0, sweep S=0..7 -> O=00000000 and Valid=0 throughout.
REQ-034 DIRECT, Enable=1, S=3'b101 -> the next cycle gives O=00100000, Idx=5, Valid=1; changing S to 3'b010 -> O=00000100 one cycle later.
REQ-035 SCAN, Div=2, from Idx=6 -> Idx steps 6, then 7, then 0, each held 3 cycles; Wrap is high only in the first cycle at O=00000001.
REQ-036 SCAN, Div=0, Load with S=3 in the same cycle as a due step -> Idx=3 (not 4) and no Wrap.
REQ-037 Mid-scan, toggle Enable 1->0->1 -> O=0 and Valid=0 while off; the scan resumes from the held Idx with a full Div period.
REQ-038 Instance with ACTIVE_LOW=1, SEL_W=4, DIRECT, S=4'hF -> O=16'h7FFF; rst asserted mid-scan -> O=16'hFFFF and Idx=0 on the next edge.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// Shared types for the scan decoder: FSM state encoding and the Mode input encodings.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Stateless binary-to-one-hot decoder, active-high.
module onehot_dec #(
    parameter  int SEL_W = 3,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] dec
);

    assign dec = OUT_W'(1) << sel;

endmodule

// File: rtl/scan_decoder.sv
// One-hot decoder with direct select and an auto-stepping scan index;
// all outputs are registered and derived from the same next-index value.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter  int SEL_W      = 3,
    parameter  int DIV_W      = 16,
    parameter  bit ACTIVE_LOW = 1'b0,
    localparam int OUT_W      = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Enable,
    input  logic             Mode,
    input  logic [SEL_W-1:0] S,
    input  logic             Load,
    input  logic [DIV_W-1:0] Div,
    output logic [OUT_W-1:0] O,
    output logic [SEL_W-1:0] Idx,
    output logic             Valid,
    output logic             Wrap
);

    function automatic logic [OUT_W-1:0] apply_polarity(input logic [OUT_W-1:0] v);
        return ACTIVE_LOW ? ~v : v;
    endfunction

    state_t           state, state_next;
    logic [DIV_W-1:0] cnt, cnt_cur, cnt_d;
    logic [SEL_W-1:0] idx_d;
    logic             valid_d, wrap_d;
    logic [OUT_W-1:0] dec;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_OFF;
        else     state <= state_next;
    end

    always_comb begin
        state_next = ST_OFF;
        if (Enable) begin
            case (Mode)
                MODE_DIRECT: state_next = ST_DIRECT;
                default:     state_next = ST_SCAN;
            endcase
        end
    end

    // Actions follow the state selected for this edge, so DIRECT has exactly
    // one cycle of latency and a freshly entered SCAN counts from zero.
    always_comb begin
        idx_d   = Idx;
        cnt_d   = '0;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        cnt_cur = (state == ST_SCAN) ? cnt : '0;
        case (state_next)
            ST_DIRECT: begin
                idx_d   = S;
                valid_d = 1'b1;
            end
            ST_SCAN: begin
                valid_d = 1'b1;
                if (Load) begin
                    idx_d = S;
                end else if (cnt_cur == Div || &cnt_cur) begin
                    // All-ones also steps, so a Div lowered below the count still
                    // steps when the counter rolls over naturally.
                    idx_d  = Idx + 1'b1;
                    wrap_d = &Idx;
                end else begin
                    cnt_d = cnt_cur + 1'b1;
                end
            end
            default: ;
        endcase
    end

    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .sel (idx_d),
        .dec (dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            Idx   <= '0;
            O     <= apply_polarity('0);
            Valid <= 1'b0;
            Wrap  <= 1'b0;
            cnt   <= '0;
        end else begin
            Idx   <= idx_d;
            O     <= valid_d ? apply_polarity(dec) : apply_polarity('0);
            Valid <= valid_d;
            Wrap  <= wrap_d;
            cnt   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: default instance plus an active-low 4-bit-select instance.
module tb_scan_decoder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // default instance (SEL_W=3, DIV_W=16, active-high)
    logic        rst, en, mode, load;
    logic [2:0]  s;
    logic [15:0] div;
    logic [7:0]  o;
    logic [2:0]  idx;
    logic        valid, wrap;

    // active-low instance (SEL_W=4, DIV_W=4)
    logic        rst2, en2, mode2, load2;
    logic [3:0]  s2;
    logic [3:0]  div2;
    logic [15:0] o2;
    logic [3:0]  idx2;
    logic        valid2, wrap2;

    scan_decoder dut (
        .clk(clk), .rst(rst), .Enable(en), .Mode(mode), .S(s), .Load(load),
        .Div(div), .O(o), .Idx(idx), .Valid(valid), .Wrap(wrap)
    );

    scan_decoder #(.SEL_W(4), .DIV_W(4), .ACTIVE_LOW(1'b1)) dut2 (
        .clk(clk), .rst(rst2), .Enable(en2), .Mode(mode2), .S(s2), .Load(load2),
        .Div(div2), .O(o2), .Idx(idx2), .Valid(valid2), .Wrap(wrap2)
    );

    int checks = 0;
    int errors = 0;

    int exp_idx [9] = '{6, 6, 7, 7, 7, 0, 0, 0, 1};
    int exp_wrap[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] e8;
        rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; s = '0; div = '0;
        rst2 = 1'b1; en2 = 1'b0; mode2 = 1'b0; load2 = 1'b0; s2 = '0; div2 = '0;
        tick();
        rst = 1'b0; rst2 = 1'b0;
        chk("rst_o",     32'(o),     32'h00);
        chk("rst_idx",   32'(idx),   32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_wrap",  32'(wrap),  32'd0);
        chk("rst_o2",    32'(o2),    32'hFFFF);

        // disabled sweep
        for (int i = 0; i < 8; i++) begin
            s = 3'(i);
            tick();
            chk("off_o",     32'(o),     32'h00);
            chk("off_valid", 32'(valid), 32'd0);
        end

        // direct decode
        en = 1'b1; mode = 1'b0; s = 3'b101;
        tick();
        chk("dir5_o",     32'(o),     32'h20);
        chk("dir5_idx",   32'(idx),   32'd5);
        chk("dir5_valid", 32'(valid), 32'd1);
        s = 3'b010;
        tick();
        chk("dir2_o",   32'(o),   32'h04);
        chk("dir2_idx", 32'(idx), 32'd2);

        // scan Div=2 from index 6
        s = 3'd6;
        tick();
        chk("pre_scan_idx", 32'(idx), 32'd6);
        mode = 1'b1; div = 16'd2;
        for (int i = 0; i < 9; i++) begin
            tick();
            e8 = 8'b1 << exp_idx[i];
            chk("scan_idx",  32'(idx),  32'(exp_idx[i]));
            chk("scan_o",    32'(o),    32'(e8));
            chk("scan_wrap", 32'(wrap), 32'(exp_wrap[i]));
        end

        // Div=0 with Load colliding with a due step
        div = 16'd0;
        tick();
        chk("d0_idx", 32'(idx), 32'd2);
        load = 1'b1; s = 3'd3;
        tick();
        chk("ld_idx",  32'(idx),  32'd3);
        chk("ld_wrap", 32'(wrap), 32'd0);
        load = 1'b0;
        tick();
        chk("d0_idx4", 32'(idx), 32'd4);
        tick(); tick(); tick();
        chk("d0_idx7", 32'(idx), 32'd7);
        load = 1'b1; s = 3'd0;
        tick();
        chk("ld7_idx",  32'(idx),  32'd0);
        chk("ld7_wrap", 32'(wrap), 32'd0);
        load = 1'b0;
        tick();
        chk("d0_idx1", 32'(idx), 32'd1);

        // Enable toggle mid-scan; Load while off is ignored
        div = 16'd2;
        tick();
        chk("pre_off_idx", 32'(idx), 32'd1);
        en = 1'b0; load = 1'b1; s = 3'd5;
        tick();
        chk("toff_o",     32'(o),     32'h00);
        chk("toff_valid", 32'(valid), 32'd0);
        chk("toff_idx",   32'(idx),   32'd1);
        tick();
        chk("toff_idx2",  32'(idx),   32'd1);
        en = 1'b1; load = 1'b0;
        tick();
        chk("ton1_idx",   32'(idx),   32'd1);
        chk("ton1_o",     32'(o),     32'h02);
        chk("ton1_valid", 32'(valid), 32'd1);
        tick();
        chk("ton2_idx", 32'(idx), 32'd1);
        tick();
        chk("ton3_idx", 32'(idx), 32'd2);

        // active-low instance: direct, Div lowered below count, reset mid-scan
        en2 = 1'b1; mode2 = 1'b0; s2 = 4'hF;
        tick();
        chk("al_dir_o",   32'(o2),   32'h7FFF);
        chk("al_dir_idx", 32'(idx2), 32'hF);
        mode2 = 1'b1; div2 = 4'd5;
        for (int i = 0; i < 4; i++) tick();
        chk("al_cnt4_idx", 32'(idx2), 32'hF);
        div2 = 4'd1;
        for (int i = 0; i < 11; i++) tick();
        chk("al_e15_idx", 32'(idx2), 32'hF);
        tick();
        chk("al_roll_idx",  32'(idx2),  32'h0);
        chk("al_roll_o",    32'(o2),    32'hFFFE);
        chk("al_roll_wrap", 32'(wrap2), 32'd1);
        tick();
        chk("al_e17_wrap", 32'(wrap2), 32'd0);
        tick();
        chk("al_e18_idx", 32'(idx2), 32'h1);
        chk("al_e18_o",   32'(o2),   32'hFFFD);
        rst2 = 1'b1;
        tick();
        chk("al_rst_o",     32'(o2),     32'hFFFF);
        chk("al_rst_idx",   32'(idx2),   32'h0);
        chk("al_rst_valid", 32'(valid2), 32'd0);
        rst2 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
